irq_ctrl: RTL

//  AXI-Lite slave interrupt aggregator, downstream of the peripheral rx_ready_int lines
//  (uart, ethernet_1, ethernet_2). Sits on a spare interconnect port.

---
 rtl/irq_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: AXI-Lite interrupt aggregator.
//
// Latches rising edges of the peripheral interrupt lines into PENDING bits.
// PENDING is masked by ENABLE, and the result drives one registered irq line
// to the core. Software reads the lowest active source ID and clears PENDING
// bits by writing 1s to them.
//
// Optional build macro:
//   IRQ_SYNC_EN  src goes through a 2-flop synchronizer before edge detection.
//                Without it, src is assumed to be synchronous to clk_50_mhz.
//
// Register map (word offsets, only addr[4:2] decoded, unused bits read 0):
//   0x00 PENDING  RO + W1C
//   0x04 ENABLE   RW
//   0x08 RAW      RO, post-sync src levels
//   0x0C ACTIVE   RO, PENDING & ENABLE
//   0x10 ID       RO, lowest active index or 32'hFFFF_FFFF when none
//   other         read 0 / SLVERR, write ignored / SLVERR
//
// Ports:
//   clk_50_mhz, rst                   clock, async active-high reset
//   src[NUM_SRC]                      interrupt request levels
//   irq                               aggregated interrupt
//   aw_*, w_*, b_*                    AXI-Lite write channels (w_strb ignored)
//   ar_*, r_*                         AXI-Lite read channels
module irq_ctrl #(
    parameter int NUM_SRC        = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                          clk_50_mhz,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src,
    output logic                          irq,
    input  logic [AXI_ADDR_WIDTH-1:0]     aw_addr,
    input  logic                          aw_valid,
    output logic                          aw_ready,
    input  logic [AXI_DATA_WIDTH-1:0]     w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0]   w_strb,
    input  logic                          w_valid,
    output logic                          w_ready,
    output logic [1:0]                    b_resp,
    output logic                          b_valid,
    input  logic                          b_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]     ar_addr,
    input  logic                          ar_valid,
    output logic                          ar_ready,
    output logic [AXI_DATA_WIDTH-1:0]     r_data,
    output logic [1:0]                    r_resp,
    output logic                          r_valid,
    input  logic                          r_ready
);

    localparam int DW = AXI_DATA_WIDTH;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [0:0]         w_state;
    logic [0:0]         r_state;
    logic [NUM_SRC-1:0] src_s;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] clr_mask;
    logic [2:0]         w_idx;
    logic [2:0]         r_idx;
    logic               w_fire;
    logic               r_fire;
    logic [DW-1:0]      rd_data;
    logic [1:0]         rd_resp;
    logic               unused_bits;

    // Zero-extend a source-wide vector to a bus word.
    function automatic logic [DW-1:0] pad_word(input logic [NUM_SRC-1:0] v);
        logic [DW-1:0] w;
        w = '0;
        w[NUM_SRC-1:0] = v;
        return w;
    endfunction

    // Index of the lowest set bit, or all ones when none is set.
    function automatic logic [DW-1:0] lowest_id(input logic [NUM_SRC-1:0] v);
        logic [DW-1:0] id;
        id = '1;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) id = DW'(i);
        end
        return id;
    endfunction

    // Stage p0/p1: optional input synchronizer
`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] src_p0;
    logic [NUM_SRC-1:0] src_p1;

    always_ff @(posedge clk_50_mhz or posedge rst) begin
        if (rst) begin
            src_p0 <= '0;
            src_p1 <= '0;
        end else begin
            src_p0 <= src;
            src_p1 <= src_p0;
        end
    end

    assign src_s = src_p1;
`else
    assign src_s = src;
`endif

    // Write and read handshakes complete on the cycle the registered ready
    // meets a still-asserted valid.
    assign w_fire   = (w_state == W_IDLE) && aw_ready && aw_valid && w_valid;
    assign r_fire   = (r_state == R_IDLE) && ar_ready && ar_valid;
    assign w_idx    = aw_addr[4:2];
    assign r_idx    = ar_addr[4:2];
    assign rise     = src_s & ~src_q;
    assign active   = pending & enable;
    assign clr_mask = (w_fire && (w_idx == 3'd0)) ? w_data[NUM_SRC-1:0] : '0;

    // Strobes and upper address/data bits carry no meaning here.
    assign unused_bits = ^{w_strb, aw_addr, ar_addr, w_data};

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (r_idx)
            3'd0:    rd_data = pad_word(pending);
            3'd1:    rd_data = pad_word(enable);
            3'd2:    rd_data = pad_word(src_s);
            3'd3:    rd_data = pad_word(active);
            3'd4:    rd_data = lowest_id(active);
            default: rd_resp = RESP_SLVERR;
        endcase
    end

    // Stage p2: edge detect, pending/enable state, registered irq
    always_ff @(posedge clk_50_mhz or posedge rst) begin
        if (rst) begin
            src_q   <= '0;
            pending <= '0;
            enable  <= '0;
            irq     <= 1'b0;
        end else begin
            src_q   <= src_s;
            // A rise on the same cycle as its clear keeps the bit set.
            pending <= (pending & ~clr_mask) | rise;
            if (w_fire && (w_idx == 3'd1)) enable <= w_data[NUM_SRC-1:0];
            irq     <= |active;
        end
    end

    always_ff @(posedge clk_50_mhz or posedge rst) begin
        if (rst) begin
            w_state  <= W_IDLE;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_ready) begin
                        aw_ready <= 1'b0;
                        w_ready  <= 1'b0;
                        if (w_fire) begin
                            b_valid <= 1'b1;
                            b_resp  <= (w_idx <= 3'd4) ? RESP_OKAY : RESP_SLVERR;
                            w_state <= W_RESP;
                        end
                    end else if (aw_valid && w_valid) begin
                        aw_ready <= 1'b1;
                        w_ready  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (b_ready) begin
                        b_valid <= 1'b0;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50_mhz or posedge rst) begin
        if (rst) begin
            r_state  <= R_IDLE;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_resp   <= RESP_OKAY;
            r_data   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_ready) begin
                        ar_ready <= 1'b0;
                        if (r_fire) begin
                            r_data  <= rd_data;
                            r_resp  <= rd_resp;
                            r_valid <= 1'b1;
                            r_state <= R_DATA;
                        end
                    end else if (ar_valid) begin
                        ar_ready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_ready) begin
                        r_valid <= 1'b0;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
